// File: rtl/halflife_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : halflife_pkg
//  Purpose  : Shared FSM state encoding and default widths for halflife_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
package halflife_pkg;

    localparam int C_N_DEFAULT  = 4;
    localparam int C_PW_DEFAULT = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_DECAY = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/halflife_tick.sv
`default_nettype none
// ============================================================================
//  Module   : halflife_tick
//  Purpose  : Half-life prescaler; pulses tick on the last of max(period,1) cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module halflife_tick
    import halflife_pkg::*;
#(
    parameter int PW = C_PW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [PW-1:0] period,
    output logic          tick
);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic [PW-1:0] last;

    // A period of 0 behaves exactly like a period of 1.
    assign last = (period == '0) ? '0 : period - PW'(1);
    assign tick = en & ~clr & (cnt_q == last);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/halflife_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : halflife_ctrl
//  Purpose  : Drives an external counter through repeated halving (half-life
//             decay); optional manual up/down via macro HALFLIFE_MANUAL_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module halflife_ctrl
    import halflife_pkg::*;
#(
    parameter int N  = C_N_DEFAULT,
    parameter int PW = C_PW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [N-1:0]  init_val,
    input  logic [PW-1:0] period,
    input  logic [N-1:0]  cnt_q,
`ifdef HALFLIFE_MANUAL_EN
    input  logic          man_up,
    input  logic          man_down,
`endif
    output logic          ctr_load,
    output logic          ctr_up,
    output logic          ctr_down,
    output logic [N-1:0]  ctr_in,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  halvings
);

    state_t       state_q;
    state_t       state_d;
    logic [N-1:0] rem_q;
    logic [N-1:0] rem_d;
    logic [N-1:0] halv_q;
    logic [N-1:0] halv_d;
    logic         armed_q;
    logic         tick;
    logic         cnt_zero;
    logic         strobe_ok;
    logic         idle_like;

    assign cnt_zero  = (cnt_q == '0);
    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    // armed_q keeps every strobe quiet during reset and the first cycle after it.
    assign strobe_ok = armed_q & ~abort;
    assign halvings  = halv_q;

    halflife_tick #(
        .PW (PW)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q != S_WAIT),
        .en     ((state_q == S_WAIT) && !cnt_zero),
        .period (period),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            halv_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            halv_q  <= halv_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start) state_d = S_LOAD;
                S_LOAD:         state_d = S_WAIT;
                S_WAIT: begin
                    if (cnt_zero)  state_d = S_DONE;
                    else if (tick) state_d = S_DECAY;
                end
                S_DECAY:        if (rem_q <= N'(1)) state_d = S_WAIT;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    // Burst length is latched once; DECAY never looks at cnt_q again.
    always_comb begin
        rem_d  = rem_q;
        halv_d = halv_q;
        if (!abort) begin
            if (idle_like && start) begin
                halv_d = '0;
            end
            if ((state_q == S_WAIT) && !cnt_zero && tick) begin
                rem_d  = cnt_q - (cnt_q >> 1);
                halv_d = (halv_q == '1) ? halv_q : halv_q + N'(1);
            end
            if (state_q == S_DECAY) begin
                rem_d = rem_q - N'(1);
            end
        end
    end

    always_comb begin
        ctr_load = 1'b0;
        ctr_up   = 1'b0;
        ctr_down = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_LOAD: begin
                busy     = 1'b1;
                ctr_load = strobe_ok;
            end
            S_WAIT:  busy = 1'b1;
            S_DECAY: begin
                busy     = 1'b1;
                ctr_down = strobe_ok;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
`ifdef HALFLIFE_MANUAL_EN
        if (idle_like && strobe_ok) begin
            ctr_up   = man_up;
            ctr_down = man_down & ~man_up;
        end
`endif
        ctr_in = ctr_load ? init_val : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_halflife_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_halflife_ctrl
//  Purpose  : Directed and randomized checks of halflife_ctrl against a
//             cycle-trace model built from the halving arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_halflife_ctrl;

    localparam int N  = 4;
    localparam int PW = 8;

    typedef struct packed {
        logic         ld;
        logic         up;
        logic         dwn;
        logic [N-1:0] din;
        logic         bsy;
        logic         don;
        logic [N-1:0] hv;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [N-1:0]  init_val = '0;
    logic [PW-1:0] period = '0;
    logic [N-1:0]  cnt = '0;
    logic          ctr_load, ctr_up, ctr_down, busy, done;
    logic [N-1:0]  ctr_in, halvings;
`ifdef HALFLIFE_MANUAL_EN
    logic          man_up = 1'b0;
    logic          man_down = 1'b0;
`endif

    int   n_cmp  = 0;
    int   n_fail = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    halflife_ctrl #(.N(N), .PW(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .init_val (init_val),
        .period   (period),
        .cnt_q    (cnt),
`ifdef HALFLIFE_MANUAL_EN
        .man_up   (man_up),
        .man_down (man_down),
`endif
        .ctr_load (ctr_load),
        .ctr_up   (ctr_up),
        .ctr_down (ctr_down),
        .ctr_in   (ctr_in),
        .busy     (busy),
        .done     (done),
        .halvings (halvings)
    );

    // The counter datapath the controller steers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          cnt <= '0;
        else if (ctr_load) cnt <= ctr_in;
        else if (ctr_up)   cnt <= cnt + 1'b1;
        else if (ctr_down) cnt <= cnt - 1'b1;
    end

    function automatic obs_t cur();
        return '{ld: ctr_load, up: ctr_up, dwn: ctr_down, din: ctr_in,
                 bsy: busy, don: done, hv: halvings};
    endfunction

    function automatic obs_t mk(input bit ld, input bit dwn, input int din,
                                input bit bsy, input bit don, input int hv);
        obs_t o;
        o.ld  = ld;
        o.up  = 1'b0;
        o.dwn = dwn;
        o.din = din[N-1:0];
        o.bsy = bsy;
        o.don = don;
        o.hv  = hv[N-1:0];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Expected per-cycle outputs from LOAD onward, derived from the decay rules.
    task automatic build_trace(input int init, input int per);
        int v, h, eff, r;
        exp_q.delete();
        eff = (per == 0) ? 1 : per;
        exp_q.push_back(mk(1, 0, init, 1, 0, 0));
        v = init;
        h = 0;
        while (v != 0) begin
            repeat (eff) exp_q.push_back(mk(0, 0, 0, 1, 0, h));
            r = v - v / 2;
            h = (h < (1 << N) - 1) ? h + 1 : h;
            repeat (r) exp_q.push_back(mk(0, 1, 0, 1, 0, h));
            v = v - r;
        end
        exp_q.push_back(mk(0, 0, 0, 1, 0, h));
        repeat (2) exp_q.push_back(mk(0, 0, 0, 0, 1, h));
    endtask

    task automatic run_trace(input string name, input int init, input int per);
        build_trace(init, per);
        @(negedge clk);
        init_val = init[N-1:0];
        period   = per[PW-1:0];
        start    = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            chk($sformatf("%s cyc%0d", name, i), 64'(cur()), 64'(exp_q[i]));
        end
        chk({name, " cnt0"}, 64'(cnt), 64'd0);
    endtask

    initial begin
        #1;
        chk("reset outputs", 64'(cur()), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("post-reset idle", 64'(cur()), 64'd0);

        run_trace("i12p3", 12, 3);
        chk("i12p3 halvings", 64'(halvings), 64'd4);
        chk("i12p3 done", 64'(done), 64'd1);

        run_trace("i0", 0, 2);
        chk("i0 halvings", 64'(halvings), 64'd0);

        run_trace("i2p0", 2, 0);
        chk("i2p0 halvings", 64'(halvings), 64'd2);

        for (int k = 0; k < 6; k++) begin
            run_trace($sformatf("rnd%0d", k), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 4)));
        end

        // Abort in the second DECAY cycle.
        @(negedge clk);
        init_val = 4'd12;
        period   = 8'd1;
        start    = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        chk("ab load", 64'(ctr_load), 64'd1);
        @(negedge clk); #1;
        chk("ab wait", 64'({busy, ctr_load, ctr_down}), 64'b100);
        @(negedge clk); #1;
        chk("ab decay1", 64'(ctr_down), 64'd1);
        @(negedge clk); abort = 1'b1; #1;
        chk("ab decay2 quiet", 64'({busy, ctr_load, ctr_up, ctr_down}), 64'b1000);
        @(negedge clk); abort = 1'b0; #1;
        chk("ab idle", 64'({busy, done, ctr_load, ctr_up, ctr_down}), 64'd0);
        chk("ab halvings", 64'(halvings), 64'd1);
        repeat (3) begin
            @(negedge clk); #1;
            chk("ab no strobe", 64'({ctr_load, ctr_up, ctr_down, busy}), 64'd0);
        end
        chk("ab cnt", 64'(cnt), 64'd11);

`ifdef HALFLIFE_MANUAL_EN
        @(negedge clk); man_up = 1'b1; #1;
        chk("man up idle", 64'({ctr_up, ctr_down}), 64'b10);
        @(negedge clk); man_down = 1'b1; #1;
        chk("man both idle", 64'({ctr_up, ctr_down}), 64'b10);
        @(negedge clk); man_up = 1'b0; #1;
        chk("man down idle", 64'({ctr_up, ctr_down}), 64'b01);
        @(negedge clk); man_down = 1'b0;
        init_val = 4'd12;
        period   = 8'd5;
        start    = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); man_up = 1'b1; #1;
        chk("man up wait", 64'({busy, ctr_up}), 64'b10);
        @(negedge clk); man_up = 1'b0; abort = 1'b1;
        @(negedge clk); abort = 1'b0;
`endif

        // Reset pulled mid-WAIT must clear outputs without a clock edge.
        @(negedge clk);
        init_val = 4'd12;
        period   = 8'd5;
        start    = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); #1;
        chk("rst pre wait", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("rst async", 64'(cur()), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst release", 64'(cur()), 64'd0);
        @(negedge clk); #1;
        chk("rst idle", 64'(cur()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/halflife_ctrl.md
HALFLIFE_CTRL -- requirements
Module: halflife_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, giving the width of the counter value, init value and halving count.
REQ-002 SHALL have parameter PW, default 8, giving the width of the half-life period.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin a decay run; level sampled each cycle.
REQ-006 SHALL have port abort  input  1  terminate any run.
REQ-007 SHALL have port init_val  input  N  value loaded into the counter at run start.
REQ-008 SHALL have port period  input  PW  half-life length in clk cycles; 0 treated as 1.
REQ-009 SHALL have port cnt_q  input  N  registered counter value fed back from the counter datapath.
REQ-010 SHALL have ports ctr_load, ctr_up, ctr_down (each output, 1) and ctr_in (output, N), the counter control strobes and load data.
REQ-011 SHALL have ports busy (output, 1), done (output, 1) and halvings (output, N), giving run status and the number of half-lives elapsed.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, WAIT, DECAY and DONE.
REQ-013 SHALL, in IDLE or DONE with start=1, go to LOAD next cycle, clear halvings and deassert done; start SHALL be ignored in LOAD, WAIT and DECAY.
REQ-014 SHALL, in LOAD, assert ctr_load=1 with ctr_in=init_val for exactly one cycle, then go to WAIT.
REQ-015 SHALL, in WAIT, go to DONE next cycle if cnt_q==0; otherwise a prescaler SHALL run 0..max(period,1)-1 and, at terminal count, latch rem=cnt_q-(cnt_q>>1), go to DECAY and increment halvings (saturating at 2^N-1).
REQ-016 SHALL, in DECAY, assert ctr_down=1 once per cycle for exactly rem cycles, decrementing an internal copy of rem without reading cnt_q, then return to WAIT with the prescaler cleared.
REQ-017 SHALL assert at most one of ctr_load, ctr_up and ctr_down in any cycle, and SHALL drive ctr_in=0 whenever ctr_load=0.
REQ-018 SHALL drive busy=1 in LOAD, WAIT and DECAY, and SHALL hold done=1 in DONE until start or abort.
REQ-019 SHALL, on abort=1 in any state, go to IDLE next cycle and assert no strobe in that cycle; halvings SHALL be held and abort SHALL take priority over start.
REQ-020 SHALL round halving toward zero: a count of 1 decays to 0 after one strobe, and init_val=0 gives DONE after the first WAIT cycle with halvings=0.

Reset
REQ-021 SHALL, while rst=0, asynchronously force state=IDLE, prescaler=0, rem=0, halvings=0 and all outputs to 0.
REQ-022 SHALL emit no strobe in the first cycle after rst deasserts.

Configuration
REQ-023 SHALL, with macro HALFLIFE_MANUAL_EN defined, add inputs man_up and man_down (each 1 bit), forwarded to ctr_up/ctr_down only in IDLE or DONE, with man_up taking priority over man_down, and ignored in all other states.
REQ-024 SHALL, without HALFLIFE_MANUAL_EN, omit those ports and tie ctr_up to 0.

Structure
REQ-025 SHALL take its state enum and default N/PW constants from a shared package halflife_pkg.
REQ-026 SHALL implement the prescaler as a sub-module halflife_tick (inputs clr, en, period; output tick).

Verification
REQ-027 Bench SHALL cover: N=4, period=3, init_val=12 -> 6, 3, 2 and 1 ctr_down pulses in four bursts separated by 3-cycle WAITs, cnt_q reaching 0, then done=1 with halvings=4.
REQ-028 Bench SHALL cover: init_val=0 -> one LOAD pulse, then done=1 two cycles later with halvings=0 and no ctr_down.
REQ-029 Bench SHALL cover: abort asserted in the 2nd DECAY cycle -> IDLE next cycle, no further strobes, busy=0.
REQ-030 Bench SHALL cover: period=0, init_val=2 -> 1-cycle WAITs, done after 2 halvings.
REQ-031 Bench SHALL cover: rst pulled low mid-WAIT -> all outputs 0 immediately without waiting for a clock edge, and IDLE after release.
REQ-032 Bench SHALL cover, with HALFLIFE_MANUAL_EN: man_up in IDLE -> ctr_up=1 the same cycle; man_up during WAIT -> ctr_up stays 0.
